// File: rtl/regfile_write_sequencer.sv
// Register-file write front end: buffers write requests in a small FIFO and drains
// them as setup/strobe/hold write_en pulses, with a combinational pending-write lookup.
module regfile_write_sequencer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  write_en,
  output logic                  busy,
  input  logic [ADDR_WIDTH-1:0] lookup_addr,
  output logic                  lookup_hit,
  output logic [DATA_WIDTH-1:0] lookup_data
);

  localparam int unsigned IDX_W = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q, count_q, count_d;
  logic [ADDR_WIDTH-1:0] write_addr_q;
  logic [DATA_WIDTH-1:0] write_data_q;
  logic                  write_en_q, write_en_d;
  logic                  full_c, push_c, pop_c;
  logic [IDX_W-1:0]      lk_idx_c;

  // Full when pointers differ only in the wrap bit.
  assign full_c    = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                     (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
  assign req_ready = !full_c && !rst;
  assign push_c    = req_valid && req_ready;
  assign busy      = (state_q != IDLE) || (count_q != '0);

  assign write_addr = write_addr_q;
  assign write_data = write_data_q;
  assign write_en   = write_en_q;

  // Next-state: pop only from IDLE or HOLD, using the registered count.
  always_comb begin
    state_d = state_q;
    pop_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop_c   = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP:  state_d = STROBE;
      STROBE: state_d = HOLD;
      HOLD: begin
        if (count_q != '0) begin
          pop_c   = 1'b1;
          state_d = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    write_en_d = (state_d == STROBE);
  end

  always_comb begin
    count_d = count_q;
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + PTR_W'(1);
      2'b01:   count_d = count_q - PTR_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      write_addr_q <= '0;
      write_data_q <= '0;
      write_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      write_en_q <= write_en_d;
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c) begin
        rd_ptr_q     <= rd_ptr_q + PTR_W'(1);
        write_addr_q <= mem_addr_q[rd_ptr_q[IDX_W-1:0]];
        write_data_q <= mem_data_q[rd_ptr_q[IDX_W-1:0]];
      end
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_addr_q[wr_ptr_q[IDX_W-1:0]] <= req_addr;
      mem_data_q[wr_ptr_q[IDX_W-1:0]] <= req_data;
    end
  end

  // In-flight entry is oldest; scanning FIFO oldest-to-youngest lets the youngest win.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    lk_idx_c    = '0;
    if ((state_q != IDLE) && (write_addr_q == lookup_addr)) begin
      lookup_hit  = 1'b1;
      lookup_data = write_data_q;
    end
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      lk_idx_c = rd_ptr_q[IDX_W-1:0] + IDX_W'(i);
      if ((PTR_W'(i) < count_q) && (mem_addr_q[lk_idx_c] == lookup_addr)) begin
        lookup_hit  = 1'b1;
        lookup_data = mem_data_q[lk_idx_c];
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Bench for regfile_write_sequencer: each accepted write is scheduled by edge number
// (accept, pop, strobe, retire) and every cycle's outputs are compared against that schedule.
module tb_regfile_write_sequencer;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 5;
  localparam int          DEPTH = 4;
  localparam int          MAXW  = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] write_data;
  logic          write_en;
  logic          busy;
  logic [AW-1:0] lookup_addr;
  logic          lookup_hit;
  logic [DW-1:0] lookup_data;

  regfile_write_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .write_addr(write_addr), .write_data(write_data), .write_en(write_en),
    .busy(busy),
    .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_data(lookup_data)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference schedule: accept edge a_e, pop edge p_e; strobe follows at p_e+1,
  // and the write stays visible to lookup until edge p_e+3.
  int            cyc;
  int            n_wr;
  int            last_p;
  int            a_e  [MAXW];
  int            p_e  [MAXW];
  logic [AW-1:0] ad_e [MAXW];
  logic [DW-1:0] d_e  [MAXW];

  function automatic int m_count(int n);
    int c = 0;
    for (int i = 0; i < n_wr; i++) if (a_e[i] <= n && n < p_e[i]) c++;
    return c;
  endfunction

  function automatic logic [31:0] m_we(int n);
    for (int i = 0; i < n_wr; i++) if (p_e[i] + 1 == n) return 32'd1;
    return 32'd0;
  endfunction

  function automatic logic [31:0] m_wr(int n, bit want_data);
    logic [31:0] r = 32'd0;
    for (int i = 0; i < n_wr; i++)
      if (p_e[i] <= n) r = want_data ? 32'(d_e[i]) : 32'(ad_e[i]);
    return r;
  endfunction

  function automatic logic [31:0] m_busy(int n);
    for (int i = 0; i < n_wr; i++) if (a_e[i] <= n && n < p_e[i] + 3) return 32'd1;
    return 32'd0;
  endfunction

  function automatic logic [31:0] m_lk(int n, logic [AW-1:0] a, bit want_data);
    for (int i = n_wr - 1; i >= 0; i--)
      if (a_e[i] <= n && n < p_e[i] + 3 && ad_e[i] == a)
        return want_data ? 32'(d_e[i]) : 32'd1;
    return 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("write_en",    32'(write_en),    m_we(cyc));
    chk("write_addr",  32'(write_addr),  m_wr(cyc, 1'b0));
    chk("write_data",  32'(write_data),  m_wr(cyc, 1'b1));
    chk("busy",        32'(busy),        m_busy(cyc));
    chk("req_ready",   32'(req_ready),   32'(!rst && (m_count(cyc) < DEPTH)));
    chk("lookup_hit",  32'(lookup_hit),  m_lk(cyc, lookup_addr, 1'b0));
    chk("lookup_data", 32'(lookup_data), m_lk(cyc, lookup_addr, 1'b1));
  endtask

  task automatic step(output bit acc);
    bit rdy;
    rdy = !rst && (m_count(cyc) < DEPTH);
    @(posedge clk);
    acc = 1'b0;
    if (rdy && req_valid && !rst && n_wr < MAXW) begin
      a_e[n_wr]  = cyc + 1;
      p_e[n_wr]  = (cyc + 2 > last_p + 3) ? cyc + 2 : last_p + 3;
      ad_e[n_wr] = req_addr;
      d_e[n_wr]  = req_data;
      last_p     = p_e[n_wr];
      n_wr++;
      acc = 1'b1;
    end
    cyc++;
    #1;
    check_all();
  endtask

  task automatic tick(input int n);
    bit dummy;
    for (int i = 0; i < n; i++) step(dummy);
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit acc = 1'b0;
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    for (int i = 0; i < 50 && !acc; i++) step(acc);
    chk("accept", 32'(acc), 32'd1);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && m_busy(cyc) != 0; i++) tick(1);
    chk("drain_busy", 32'(busy), 32'd0);
  endtask

  task automatic model_clear();
    n_wr   = 0;
    last_p = -100;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; lookup_addr = '0;
    cyc = 0;
    model_clear();
    tick(3);
    rst = 1'b0;
    tick(2);

    // Single write with lookup on the same register.
    lookup_addr = 5'd5;
    push(5'd5, 16'hBEEF);
    tick(6);

    // Fill and backpressure: six requests with valid held high.
    lookup_addr = 5'd2;
    for (int i = 0; i < 6; i++) push(AW'(i), DW'(16'hA000 + i));
    drain();

    // Pointer wrap with random gaps between requests.
    lookup_addr = 5'd7;
    for (int i = 0; i < 10; i++) begin
      push(AW'(i), DW'(16'h100 + i));
      tick($urandom_range(0, 3));
    end
    drain();

    // Lookup priority between two queued writes to the same register.
    lookup_addr = 5'd3;
    push(5'd3, 16'h1111);
    push(5'd3, 16'h2222);
    drain();
    tick(2);
    lookup_addr = 5'd7;
    tick(2);

    // Random traffic: exercises push during HOLD, full/pop overlap, mixed lookups.
    for (int i = 0; i < 80; i++) begin
      bit acc;
      req_valid   = 1'($urandom_range(0, 1));
      req_addr    = AW'($urandom_range(0, 7));
      req_data    = DW'($urandom);
      lookup_addr = AW'($urandom_range(0, 7));
      step(acc);
    end
    req_valid = 1'b0;
    drain();

    // Reset during a strobe with writes still queued.
    lookup_addr = 5'd9;
    for (int i = 0; i < 5; i++) push(AW'(8 + i), DW'(16'hC000 + i));
    for (int i = 0; i < 20 && m_we(cyc) == 0; i++) tick(1);
    chk("pre_rst_strobe", 32'(write_en), 32'd1);
    chk("pre_rst_pending", 32'(m_count(cyc) >= 3), 32'(busy));
    rst = 1'b1;
    model_clear();
    #1;
    chk("rst_write_en", 32'(write_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_addr", 32'(write_addr), 32'd0);
    tick(2);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    tick(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
